// File: rtl/capture_len_sequencer_if.sv
// rtl/capture_len_sequencer_if.sv - command and burst-length handshake bundle for the capture sequencer
interface capture_len_sequencer_if #(
   parameter int C_LEN_WIDTH    = 32,
   parameter int C_REPEAT_WIDTH = 16
);
   logic [C_LEN_WIDTH-1:0]    cmd_len;
   logic [C_REPEAT_WIDTH-1:0] cmd_repeat;
   logic                      cmd_wait_trig;
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [C_LEN_WIDTH-1:0]    stream_len;
   logic                      len_valid;
   logic                      len_ready;

   // master drives commands and consumes lengths; slave is the sequencer
   modport master (
      output cmd_len, cmd_repeat, cmd_wait_trig, cmd_valid, len_ready,
      input  cmd_ready, stream_len, len_valid
   );

   modport slave (
      input  cmd_len, cmd_repeat, cmd_wait_trig, cmd_valid, len_ready,
      output cmd_ready, stream_len, len_valid
   );
endinterface

// File: rtl/capture_len_sequencer.sv
// rtl/capture_len_sequencer.sv - queues capture commands and issues burst lengths to the packetiser
module capture_len_sequencer #(
   parameter int C_LEN_WIDTH    = 32,
   parameter int C_REPEAT_WIDTH = 16,
   parameter int C_FIFO_AW      = 3
) (
   input  logic                  S_AXIS_ACLK,
   input  logic                  S_AXIS_ARESETN,
   capture_len_sequencer_if.slave seq_if,
   input  logic                  enable,
   input  logic                  abort,
   input  logic                  trigger,
   output logic                  busy,
   output logic [C_FIFO_AW:0]    fifo_level,
   output logic [31:0]           bursts_issued,
   output logic                  cmd_done,
   output logic                  err_zero_len
);

   localparam int                 DEPTH   = 2 ** C_FIFO_AW;
   localparam logic [C_FIFO_AW:0] DEPTH_L = (C_FIFO_AW + 1)'(DEPTH);
   localparam logic [C_FIFO_AW:0] LVL_ONE = (C_FIFO_AW + 1)'(1);
   localparam logic [C_REPEAT_WIDTH-1:0] REP_ONE = C_REPEAT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [C_LEN_WIDTH-1:0]    len_mem  [DEPTH];
   logic [C_REPEAT_WIDTH-1:0] rep_mem  [DEPTH];
   logic                      wait_mem [DEPTH];

   logic [C_FIFO_AW-1:0]      wr_ptr, rd_ptr;
   logic [C_FIFO_AW:0]        level;
   logic [C_LEN_WIDTH-1:0]    cur_len;
   logic [C_REPEAT_WIDTH-1:0] remaining;
   logic                      cur_wait;

   logic                      push, pop, hs, zero_drop, last_burst;
   logic [C_LEN_WIDTH-1:0]    head_len;
   logic [C_REPEAT_WIDTH-1:0] head_rep;
   logic                      head_wait;

   // ready comes from registered occupancy only, so a full FIFO never passes through
   assign seq_if.cmd_ready  = (level != DEPTH_L);
   assign push              = seq_if.cmd_valid && seq_if.cmd_ready && !abort;
   assign seq_if.len_valid  = (state == ST_ISSUE);
   assign seq_if.stream_len = cur_len;
   assign fifo_level        = level;
   assign busy              = (state != ST_IDLE) || (level != '0);

   assign head_len  = len_mem[rd_ptr];
   assign head_rep  = (rep_mem[rd_ptr] == '0) ? REP_ONE : rep_mem[rd_ptr];
   assign head_wait = wait_mem[rd_ptr];

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      hs         = 1'b0;
      zero_drop  = 1'b0;
      last_burst = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && (level != '0)) begin
               pop = 1'b1;
               if (head_len == '0) begin
                  zero_drop = 1'b1;
               end else begin
                  state_nxt = head_wait ? ST_ARM : ST_ISSUE;
               end
            end
         end
         ST_ARM: begin
            if (trigger) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (seq_if.len_ready) begin
               hs = 1'b1;
               if (remaining == REP_ONE) begin
                  last_burst = 1'b1;
                  state_nxt  = ST_IDLE;
               end else begin
                  state_nxt = cur_wait ? ST_ARM : ST_ISSUE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // abort wins, but a handshake completing this cycle still counts
      if (abort) begin
         state_nxt  = ST_IDLE;
         pop        = 1'b0;
         zero_drop  = 1'b0;
         last_burst = 1'b0;
      end
   end

   always_ff @(posedge S_AXIS_ACLK) begin
      if (push) begin
         len_mem[wr_ptr]  <= seq_if.cmd_len;
         rep_mem[wr_ptr]  <= seq_if.cmd_repeat;
         wait_mem[wr_ptr] <= seq_if.cmd_wait_trig;
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         cur_len       <= '0;
         remaining     <= '0;
         cur_wait      <= 1'b0;
         bursts_issued <= '0;
         cmd_done      <= 1'b0;
         err_zero_len  <= 1'b0;
      end else begin
         cmd_done     <= last_burst;
         err_zero_len <= zero_drop;
         if (hs) begin
            bursts_issued <= bursts_issued + 32'd1;
         end
         if (abort) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            remaining <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   level <= level + LVL_ONE;
               2'b01:   level <= level - LVL_ONE;
               default: level <= level;
            endcase
            // zero-length heads leave cur_len alone so stream_len keeps its last value
            if (pop && (head_len != '0)) begin
               cur_len   <= head_len;
               remaining <= head_rep;
               cur_wait  <= head_wait;
            end else if (last_burst) begin
               remaining <= '0;
            end else if (hs) begin
               remaining <= remaining - REP_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_capture_len_sequencer.sv
// tb/tb_capture_len_sequencer.sv - scoreboard bench for capture_len_sequencer
module tb_capture_len_sequencer;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        abort;
   logic        trigger;
   logic        busy;
   logic [3:0]  fifo_level;
   logic [31:0] bursts_issued;
   logic        cmd_done;
   logic        err_zero_len;

   capture_len_sequencer_if #(.C_LEN_WIDTH(32), .C_REPEAT_WIDTH(16)) sif ();

   capture_len_sequencer #(
      .C_LEN_WIDTH(32),
      .C_REPEAT_WIDTH(16),
      .C_FIFO_AW(3)
   ) dut (
      .S_AXIS_ACLK   (clk),
      .S_AXIS_ARESETN(rst_n),
      .seq_if        (sif),
      .enable        (enable),
      .abort         (abort),
      .trigger       (trigger),
      .busy          (busy),
      .fifo_level    (fifo_level),
      .bursts_issued (bursts_issued),
      .cmd_done      (cmd_done),
      .err_zero_len  (err_zero_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int last_done_hs = -1;
   logic [31:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every accepted length is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (sif.len_valid && sif.len_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_burst", 64'(sif.stream_len), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("stream_len", 64'(sif.stream_len), 64'(exp_q.pop_front()));
            end
         end
         if (cmd_done) begin
            done_cnt++;
            last_done_hs = hs_cnt;
         end
         if (err_zero_len) begin
            err_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [31:0] len, input logic [15:0] rep, input logic wt);
      sif.cmd_valid     = 1'b1;
      sif.cmd_len       = len;
      sif.cmd_repeat    = rep;
      sif.cmd_wait_trig = wt;
      tick();
      sif.cmd_valid     = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_len_valid"}, 64'(sif.len_valid), 64'd0);
      check({tag, "_stream_len"}, 64'(sif.stream_len), 64'd0);
      check({tag, "_cmd_ready"}, 64'(sif.cmd_ready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
      check({tag, "_bursts"}, 64'(bursts_issued), 64'd0);
      check({tag, "_cmd_done"}, 64'(cmd_done), 64'd0);
      check({tag, "_err_zero"}, 64'(err_zero_len), 64'd0);
   endtask

   initial begin
      int hs0, done0, err0, unstable;
      logic [63:0] seen_mask, want_mask;

      rst_n = 1'b0;
      enable = 1'b0;
      abort = 1'b0;
      trigger = 1'b0;
      sif.cmd_valid = 1'b0;
      sif.cmd_len = '0;
      sif.cmd_repeat = '0;
      sif.cmd_wait_trig = 1'b0;
      sif.len_ready = 1'b0;
      tick();
      tick();
      check_reset_values("rst");
      rst_n = 1'b1;
      tick();

      // single burst: len_valid two cycles after the push
      enable = 1'b1;
      sif.len_ready = 1'b1;
      exp_q.push_back(32'd16);
      push_cmd(32'd16, 16'd1, 1'b0);
      check("t1_lv_t1", 64'(sif.len_valid), 64'd0);
      tick();
      check("t1_lv_t2", 64'(sif.len_valid), 64'd1);
      tick();
      tick();
      check("t1_busy", 64'(busy), 64'd0);
      check("t1_bursts", 64'(bursts_issued), 64'd1);
      check("t1_done", 64'(done_cnt), 64'd1);

      // three bursts with a sparse len_ready
      sif.len_ready = 1'b0;
      hs0 = hs_cnt;
      done0 = done_cnt;
      unstable = 0;
      repeat (3) exp_q.push_back(32'd4);
      push_cmd(32'd4, 16'd3, 1'b0);
      for (int i = 0; i < 24; i++) begin
         sif.len_ready = ((i % 6) == 5);
         if (sif.len_valid && (sif.stream_len != 32'd4)) unstable++;
         tick();
      end
      sif.len_ready = 1'b0;
      check("t2_hs", 64'(hs_cnt - hs0), 64'd3);
      check("t2_done", 64'(done_cnt - done0), 64'd1);
      check("t2_done_on_last", 64'(last_done_hs), 64'(hs_cnt));
      check("t2_stable", 64'(unstable), 64'd0);
      check("t2_bursts", 64'(bursts_issued), 64'd4);

      // fill past depth with popping disabled, then drain in order
      enable = 1'b0;
      sif.len_ready = 1'b1;
      hs0 = hs_cnt;
      for (int k = 0; k < 9; k++) begin
         if (k < 8) exp_q.push_back(32'(k + 1));
         sif.cmd_valid = 1'b1;
         sif.cmd_len = 32'(k + 1);
         sif.cmd_repeat = 16'd1;
         sif.cmd_wait_trig = 1'b0;
         check($sformatf("t3_ready_%0d", k), 64'(sif.cmd_ready), (k < 8) ? 64'd1 : 64'd0);
         tick();
      end
      sif.cmd_valid = 1'b0;
      check("t3_level_full", 64'(fifo_level), 64'd8);
      check("t3_busy_full", 64'(busy), 64'd1);
      check("t3_lv_blocked", 64'(sif.len_valid), 64'd0);
      enable = 1'b1;
      repeat (40) tick();
      check("t3_level_empty", 64'(fifo_level), 64'd0);
      check("t3_hs", 64'(hs_cnt - hs0), 64'd8);

      // zero-length command is dropped with an error pulse
      hs0 = hs_cnt;
      err0 = err_cnt;
      exp_q.push_back(32'd8);
      push_cmd(32'd0, 16'd1, 1'b0);
      push_cmd(32'd8, 16'd1, 1'b0);
      repeat (10) tick();
      check("t4_err", 64'(err_cnt - err0), 64'd1);
      check("t4_hs", 64'(hs_cnt - hs0), 64'd1);

      // trigger-gated bursts; the early trigger while idle is ignored
      done0 = done_cnt;
      seen_mask = '0;
      want_mask = '0;
      want_mask[11] = 1'b1;
      want_mask[31] = 1'b1;
      repeat (2) exp_q.push_back(32'd12);
      sif.cmd_len = 32'd12;
      sif.cmd_repeat = 16'd2;
      sif.cmd_wait_trig = 1'b1;
      for (int c = 0; c <= 40; c++) begin
         trigger = (c == 5) || (c == 10) || (c == 30);
         sif.cmd_valid = (c == 6);
         seen_mask[c] = sif.len_valid;
         tick();
      end
      trigger = 1'b0;
      sif.cmd_valid = 1'b0;
      check("t5_lv_cycles", seen_mask, want_mask);
      check("t5_done", 64'(done_cnt - done0), 64'd1);

      // abort during ISSUE with three commands queued
      sif.len_ready = 1'b0;
      done0 = done_cnt;
      push_cmd(32'd20, 16'd1, 1'b0);
      push_cmd(32'd21, 16'd1, 1'b0);
      push_cmd(32'd22, 16'd1, 1'b0);
      push_cmd(32'd23, 16'd1, 1'b0);
      check("t6_level_pre", 64'(fifo_level), 64'd3);
      check("t6_lv_pre", 64'(sif.len_valid), 64'd1);
      check("t6_len_pre", 64'(sif.stream_len), 64'd20);
      abort = 1'b1;
      sif.cmd_valid = 1'b1;
      sif.cmd_len = 32'd99;
      sif.cmd_wait_trig = 1'b0;
      tick();
      abort = 1'b0;
      sif.cmd_valid = 1'b0;
      check("t6_lv_post", 64'(sif.len_valid), 64'd0);
      check("t6_level_post", 64'(fifo_level), 64'd0);
      check("t6_busy_post", 64'(busy), 64'd0);
      repeat (3) tick();
      check("t6_no_done", 64'(done_cnt - done0), 64'd0);

      // asynchronous reset while armed
      push_cmd(32'd5, 16'd1, 1'b1);
      push_cmd(32'd6, 16'd1, 1'b0);
      tick();
      check("t7_busy_arm", 64'(busy), 64'd1);
      check("t7_level_arm", 64'(fifo_level), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("arst");
      tick();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/capture_len_sequencer.md
Name: capture_len_sequencer

Overview:
- Upstream stage of the stream-length packetiser: queues capture commands (length, repeat count, trigger-wait flag) and issues each burst length over the stream_len/len_valid/len_ready handshake.
- The downstream packetiser converts each accepted length into one TLAST-terminated packet.
- Supports multi-burst commands, optional per-burst trigger gating, zero-length rejection, and abort/flush.

Parameters:
- C_LEN_WIDTH, 32, width of burst length (matches downstream stream_len).
- C_REPEAT_WIDTH, 16, width of per-command repeat count.
- C_FIFO_AW, 3, command FIFO address width; depth = 2**C_FIFO_AW (8).

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low.
- cmd_len  in  C_LEN_WIDTH  samples per burst.
- cmd_repeat  in  C_REPEAT_WIDTH  bursts per command; 0 treated as 1.
- cmd_wait_trig  in  1  1 = each burst waits for trigger.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- enable  in  1  allows popping new commands.
- abort  in  1  synchronous abort/flush pulse.
- trigger  in  1  burst trigger, sampled level.
- stream_len  out  C_LEN_WIDTH  burst length to packetiser.
- len_valid  out  1  stream_len valid.
- len_ready  in  1  packetiser idle/accepting.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- fifo_level  out  C_FIFO_AW+1  queued commands.
- bursts_issued  out  32  accepted len handshakes; wraps.
- cmd_done  out  1  1-cycle pulse on final burst of a command.
- err_zero_len  out  1  1-cycle pulse when a zero-length command is discarded.

Behaviour:
- Reset (async, ARESETN=0) clears FIFO pointers, FSM→IDLE, and all registers.
- Output values during reset: len_valid=0, stream_len=0, cmd_ready=1, busy=0, fifo_level=0, bursts_issued=0, cmd_done=0, err_zero_len=0.
- Reset mid-burst drops len_valid immediately, with no handshake completion.
- FIFO:
  - Push on cmd_valid&&cmd_ready; cmd_ready = (fifo_level != depth), from registered state.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle (no pass-through).
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, ARM, ISSUE.
  - IDLE: len_valid=0. If enable && fifo_level>0, pop the head into cur_len, remaining=max(cmd_repeat,1), and cur_wait.
    - cur_len==0: pulse err_zero_len, stay IDLE (next entry may pop next cycle).
    - Otherwise go to ARM if cur_wait, else ISSUE.
  - ARM: len_valid=0. trigger==1 in a cycle → ISSUE next cycle. Trigger in any other state is ignored.
  - ISSUE: len_valid=1, stream_len=cur_len, held stable until handshake.
    - On len_valid&&len_ready: bursts_issued++.
    - If remaining==1: pulse cmd_done, go IDLE.
    - Else remaining--, go ARM (cur_wait) or stay ISSUE.
    - Staying in ISSUE with len_valid high is legal; the packetiser deasserts len_ready the cycle after acceptance.
- Latency:
  - Push at cycle t into an empty FIFO with FSM IDLE and enable=1: pop at t+1, len_valid=1 at t+2 (no trigger wait).
  - With wait: trigger seen at cycle u → len_valid at u+1.
- enable=0 blocks only IDLE pops; an in-progress command runs to completion.
- abort=1 (highest priority after reset):
  - FSM→IDLE, len_valid drops next cycle, FIFO flushed (fifo_level=0), remaining cleared.
  - A push in the same cycle is discarded.
  - No cmd_done pulse.
  - An already-accepted burst is unaffected downstream.
- Handshake completing in the same cycle as abort still counts in bursts_issued.
- busy = (state!=IDLE) || (fifo_level!=0).
- bursts_issued wraps 0xFFFFFFFF→0.
- stream_len retains its last value when len_valid=0.

Test Plan:
- Single command len=16, repeat=1, wait=0, len_ready=1 → len_valid rises 2 cycles after push; one handshake; cmd_done pulse; bursts_issued=1; busy=0 after.
- len=4, repeat=3, wait=0, len_ready pulsed 1 cycle every 6 cycles → exactly 3 handshakes, stream_len=4 held stable throughout, cmd_done only on the 3rd.
- Push 9 commands back-to-back with enable=0 → cmd_ready falls after the 8th, 9th not accepted, fifo_level=8; enable=1 drains in order.
- Command len=0, then len=8 → err_zero_len pulses once, no len_valid for the first, second issues normally.
- wait=1, repeat=2, trigger pulses at cycles 10 and 30 → len_valid at 11 and 31 only; trigger at cycle 5 (IDLE) ignored.
- Abort during ISSUE with 3 queued commands → len_valid=0 next cycle, fifo_level=0, no cmd_done; async reset mid-ARM → all outputs at reset values immediately.
